// File: rtl/cmp_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Brief    : Shared types and helpers for the serial magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Compare mode presented alongside the operands.
  typedef enum logic [1:0] {
    OP_SLT  = 2'b00,
    OP_SLTU = 2'b01,
    OP_EQ   = 2'b10,
    OP_SLE  = 2'b11
  } op_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Operand width must split into a whole number of slices.
  function automatic bit width_ok(input int n, input int w);
    return (w > 0) && (n >= w) && ((n % w) == 0);
  endfunction

  // Maps the raw less-than / equal pair onto the requested mode.
  function automatic logic select_result(input op_t op, input logic lt, input logic eq);
    logic r;
    case (op)
      OP_EQ:   r = eq;
      OP_SLE:  r = lt | eq;
      default: r = lt;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : cmp_serial_if
// Brief    : Operand/result handshake bundle for cmp_serial.
// Revision : 1.0 - initial release
// ============================================================================
interface cmp_serial_if #(
  parameter int N = 32
);
  import cmp_pkg::*;

  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  op_t          op;
  logic         o_valid;
  logic         o_ready;
  logic         out;
  logic         lt;
  logic         eq;

  // Producer/consumer side.
  modport master (
    output i_valid, a, b, op, o_ready,
    input  i_ready, o_valid, out, lt, eq
  );

  // Comparator side.
  modport slave (
    input  i_valid, a, b, op, o_ready,
    output i_ready, o_valid, out, lt, eq
  );
endinterface
`default_nettype wire

// File: rtl/cmp_serial_slice_cmp.sv
`default_nettype none
// ============================================================================
// Module   : slice_cmp
// Brief    : Combinational unsigned compare of one W-bit slice.
// Revision : 1.0 - initial release
// ============================================================================
module slice_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq
);

  // Signedness is already folded into the operands upstream.
  assign lt = (a < b);
  assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/cmp_serial.sv
`default_nettype none
// ============================================================================
// Module   : cmp_serial
// Brief    : Multi-cycle signed/unsigned comparator, W bits per cycle,
//            MSB slice first, with optional early exit.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_serial
  import cmp_pkg::*;
#(
  parameter int N          = 32,
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_serial_if.slave  bus
);

  localparam int             c_s     = N / W;
  localparam int             c_kw    = (c_s > 1) ? $clog2(c_s) : 1;
  localparam int             c_slots = 1 << c_kw;
  localparam logic [c_kw-1:0] c_k_top = c_kw'(c_s - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [N-1:0]   c_msb   = {1'b1, {(N-1){1'b0}}};

  generate
    if (!width_ok(N, W)) begin : g_bad_width
      $error("cmp_serial: N must be a positive multiple of W");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  op_t             r_op;
  logic [c_kw-1:0] r_k;
  logic            r_dec;
  logic            r_lt;
  logic            r_eq;
  logic            r_out;
  logic            r_ovalid;

  logic            w_capture;
  logic            w_decide;
  logic            w_k_step;
  logic            w_lt_new;
  logic            w_eq_new;
  logic [W-1:0]    w_sa;
  logic [W-1:0]    w_sb;
  logic            w_slt;
  logic            w_seq;

  // Slice mux: padded to a power of two so every k value selects something.
  logic [W-1:0] w_sa_arr [c_slots];
  logic [W-1:0] w_sb_arr [c_slots];

  generate
    for (genvar s = 0; s < c_slots; s++) begin : g_slice
      if (s < c_s) begin : g_real
        assign w_sa_arr[s] = r_a[s*W +: W];
        assign w_sb_arr[s] = r_b[s*W +: W];
      end else begin : g_pad
        assign w_sa_arr[s] = '0;
        assign w_sb_arr[s] = '0;
      end
    end
  endgenerate

  assign w_sa = w_sa_arr[r_k];
  assign w_sb = w_sb_arr[r_k];

  slice_cmp #(.W(W)) u_slice (
    .a  (w_sa),
    .b  (w_sb),
    .lt (w_slt),
    .eq (w_seq)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_decide     = 1'b0;
    w_k_step     = 1'b0;
    w_lt_new     = 1'b0;
    w_eq_new     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_valid) begin
          w_capture    = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_seq && !r_dec) begin
          // First differing slice fixes the answer.
          w_decide = 1'b1;
          w_lt_new = w_slt;
          w_eq_new = 1'b0;
          if (EARLY_EXIT) w_state_next = ST_DONE;
        end else if (w_seq && !r_dec && (r_k == '0)) begin
          w_decide = 1'b1;
          w_lt_new = 1'b0;
          w_eq_new = 1'b1;
        end
        if (r_k == '0) w_state_next = ST_DONE;
        else           w_k_step     = 1'b1;
      end
      ST_DONE: begin
        if (bus.o_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture, slice counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_SLT;
      r_k      <= '0;
      r_dec    <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_out    <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_a   <= (bus.op == OP_SLTU) ? bus.a : (bus.a ^ c_msb);
        r_b   <= (bus.op == OP_SLTU) ? bus.b : (bus.b ^ c_msb);
        r_op  <= bus.op;
        r_k   <= c_k_top;
        r_dec <= 1'b0;
      end else if (w_k_step) begin
        r_k <= r_k - 1'b1;
      end
      if (w_decide) begin
        r_dec <= 1'b1;
        r_lt  <= w_lt_new;
        r_eq  <= w_eq_new;
        r_out <= select_result(r_op, w_lt_new, w_eq_new);
      end
      r_ovalid <= (w_state_next == ST_DONE);
    end
  end

  assign bus.i_ready = (r_state == ST_IDLE);
  assign bus.o_valid = r_ovalid;
  assign bus.out     = r_out;
  assign bus.lt      = r_lt;
  assign bus.eq      = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_cmp_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmp_serial
// Brief    : Self-checking bench for cmp_serial over four configurations:
//            0: W=8 early exit, 1: W=8 full scan, 2: W=32, 3: W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_serial;
  import cmp_pkg::*;

  localparam int c_n = 32;

  function automatic int inst_w(input int i);
    case (i)
      2:       return 32;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic bit inst_ee(input int i);
    return (i != 1);
  endfunction

  typedef struct {
    int         idx;
    logic [2:0] res;   // {out, lt, eq}
    int         lat;
  } exp_t;

  exp_t sb [$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  v;
  logic [3:0]  ordy;
  logic [31:0] a_s  [4];
  logic [31:0] b_s  [4];
  logic [1:0]  op_s [4];
  logic [3:0]  rdy, ov, ro, rl, re;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int GW = inst_w(g);
      localparam bit GE = inst_ee(g);
      cmp_serial_if #(.N(c_n)) bus ();
      assign bus.i_valid = v[g];
      assign bus.a       = a_s[g];
      assign bus.b       = b_s[g];
      assign bus.op      = op_t'(op_s[g]);
      assign bus.o_ready = ordy[g];
      assign rdy[g]      = bus.i_ready;
      assign ov[g]       = bus.o_valid;
      assign ro[g]       = bus.out;
      assign rl[g]       = bus.lt;
      assign re[g]       = bus.eq;
      cmp_serial #(.N(c_n), .W(GW), .EARLY_EXIT(GE)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
    end
  endgenerate

  // Reference behaviour: {out, lt, eq}.
  function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
    logic l, e, r;
    e = (x == y);
    l = (o == 2'b01) ? (x < y) : ($signed(x) < $signed(y));
    case (o)
      2'b10:   r = e;
      2'b11:   r = ($signed(x) <= $signed(y));
      default: r = l;
    endcase
    return {r, l, e};
  endfunction

  // Slices examined: down to the slice holding the highest differing bit.
  function automatic int exp_lat(input int idx, input logic [31:0] x, input logic [31:0] y);
    int          s;
    logic [31:0] d;
    s = c_n / inst_w(idx);
    d = x ^ y;
    if (!inst_ee(idx) || d == 32'd0) return s;
    for (int bi = 31; bi >= 0; bi--) begin
      if (d[bi]) return s - (bi / inst_w(idx));
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction with latency, result and return-to-idle checks.
  task automatic run_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] o, input int hold, input string tag);
    exp_t e;
    exp_t p;
    int   lat;
    @(negedge clk);
    chk($sformatf("%s ready", tag), 32'(rdy[idx]), 32'd1);
    a_s[idx]  = x;
    b_s[idx]  = y;
    op_s[idx] = o;
    v[idx]    = 1'b1;
    e.idx = idx;
    e.res = model(x, y, o);
    e.lat = exp_lat(idx, x, y);
    sb.push_back(e);
    @(posedge clk); #1;
    v[idx] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ov[idx] !== 1'b1 && lat < 64);
    p = sb.pop_front();
    chk($sformatf("%s latency", tag), 32'(lat), 32'(p.lat));
    chk($sformatf("%s out", tag), 32'(ro[idx]), 32'(p.res[2]));
    chk($sformatf("%s lt", tag), 32'(rl[idx]), 32'(p.res[1]));
    chk($sformatf("%s eq", tag), 32'(re[idx]), 32'(p.res[0]));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    chk($sformatf("%s idle", tag), {30'd0, rdy[idx], ov[idx]}, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    exp_t        p;
    int          lat;
    logic [31:0] x, y;
    logic [1:0]  o;

    rst_n = 1'b0;
    v     = '0;
    ordy  = '0;
    for (int i = 0; i < 4; i++) begin
      a_s[i]  = '0;
      b_s[i]  = '0;
      op_s[i] = '0;
    end

    // Reset values.
    #1;
    chk("reset i_ready", 32'(rdy), 32'hF);
    chk("reset o_valid", 32'(ov), 32'h0);
    chk("reset out/lt/eq", {20'd0, ro, rl, re}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on the early-exit and full-scan W=8 instances.
    for (int i = 0; i < 2; i++) begin
      run_op(i, 32'h0, 32'h0, 2'b00, 0, $sformatf("i%0d zero slt", i));
      run_op(i, 32'h0, 32'h0, 2'b10, 0, $sformatf("i%0d zero eq", i));
      run_op(i, 32'h0, 32'h0, 2'b11, 1, $sformatf("i%0d zero sle", i));
      run_op(i, 32'hFFFFFFFF, 32'h1, 2'b00, 0, $sformatf("i%0d m1 slt", i));
      run_op(i, 32'hFFFFFFFF, 32'h1, 2'b01, 0, $sformatf("i%0d m1 sltu", i));
      run_op(i, 32'h7FFFFFFF, 32'h80000000, 2'b00, 0, $sformatf("i%0d max slt", i));
      run_op(i, 32'h7FFFFFFF, 32'h80000000, 2'b01, 0, $sformatf("i%0d max sltu", i));
      run_op(i, 32'h12345600, 32'h12345601, 2'b01, 2, $sformatf("i%0d low sltu", i));
      run_op(i, 32'h80000000, 32'h80000000, 2'b11, 0, $sformatf("i%0d min sle", i));
    end

    // Asynchronous reset in the middle of a compare.
    run_op(0, 32'h0, 32'h0, 2'b10, 0, "pre-reset eq");
    @(negedge clk);
    a_s[0] = 32'h0; b_s[0] = 32'h0; op_s[0] = 2'b00; v[0] = 1'b1;
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid-run busy", 32'(rdy[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset o_valid", 32'(ov[0]), 32'd0);
    chk("async reset out/lt/eq", {29'd0, ro[0], rl[0], re[0]}, 32'd0);
    chk("async reset i_ready", 32'(rdy[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no pulse after reset", 32'(ov[0]), 32'd0);
    end
    run_op(0, 32'hFFFFFFFE, 32'hFFFFFFFF, 2'b00, 0, "post-reset slt");

    // Back-pressure with stray i_valid activity in RUN and DONE.
    @(negedge clk);
    a_s[0] = 32'h12345600; b_s[0] = 32'h12345601; op_s[0] = 2'b01; v[0] = 1'b1;
    e.idx = 0;
    e.res = model(32'h12345600, 32'h12345601, 2'b01);
    e.lat = 4;
    sb.push_back(e);
    @(posedge clk); #1;
    a_s[0] = 32'hFFFFFFFF; b_s[0] = 32'h0; op_s[0] = 2'b00;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ov[0] !== 1'b1 && lat < 64);
    p = sb.pop_front();
    chk("bp latency", 32'(lat), 32'(p.lat));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp hold%0d valid", c), 32'(ov[0]), 32'd1);
      chk($sformatf("bp hold%0d result", c), {29'd0, ro[0], rl[0], re[0]}, 32'(p.res));
      chk($sformatf("bp hold%0d i_ready", c), 32'(rdy[0]), 32'd0);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    v[0]    = 1'b0;
    ordy[0] = 1'b0;
    chk("bp release idle", {30'd0, rdy[0], ov[0]}, 32'd2);
    @(posedge clk); #1;
    chk("bp nothing accepted", 32'(rdy[0]), 32'd1);

    // Random traffic on every configuration.
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < ((i == 1) ? 300 : 1000); n++) begin
        x = $urandom;
        case ($urandom_range(0, 3))
          0:       y = x;
          1:       y = x ^ (32'h1 << $urandom_range(0, 31));
          default: y = $urandom;
        endcase
        o = 2'($urandom_range(0, 3));
        run_op(i, x, y, o, int'($urandom_range(0, 3)), $sformatf("rnd i%0d n%0d", i, n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
